// File: rtl/xnor_cmp_pkg.sv
// Shared types and width helpers for the bit-serial XNOR comparator.
// Optional early-exit build: XNOR_CMP_EARLY_EXIT_EN.
package xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cw_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int iw_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/xnor_nor_cell.sv
// One-bit equivalence cell built only from NOR gates.
// y is a XNOR b; diff is its NOR-inverted complement.
module xnor_nor_cell (
  input  logic a,
  input  logic b,
  output logic y,
  output logic diff
);

  logic n1;
  logic n2;
  logic n3;
  logic n4;

  assign n1   = ~(a | b);
  assign n2   = ~(a | n1);
  assign n3   = ~(b | n1);
  assign n4   = ~(n2 | n3);
  assign diff = ~(n4 | n4);
  assign y    = n4;

endmodule

// File: rtl/xnor_serial_cmp_ctrl.sv
// Bit-serial W-bit equality comparator sequencing one shared XNOR cell.
// Build option XNOR_CMP_EARLY_EXIT_EN stops the scan on the first mismatch.
module xnor_serial_cmp_ctrl
  import xnor_cmp_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = cw_w(W),
  localparam int IW = iw_w(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] mismatch_cnt,
  output logic [IW-1:0] first_diff
);

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [IW-1:0] idx;
  logic [CW-1:0] acc_cnt;
  logic [IW-1:0] acc_first;
  logic          seen;

  logic          x;
  logic          diff;
  logic [CW-1:0] nxt_cnt;
  logic [IW-1:0] nxt_first;
  logic          last;

  xnor_nor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .y    (x),
    .diff (diff)
  );

  always_comb begin
    nxt_cnt   = acc_cnt;
    nxt_first = acc_first;
    if (!x) begin
      nxt_cnt = acc_cnt + CW'(1);
      if (!seen) nxt_first = idx;
    end
`ifdef XNOR_CMP_EARLY_EXIT_EN
    last = (idx == IW'(W - 1)) || diff;
`else
    last = (idx == IW'(W - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      idx          <= '0;
      acc_cnt      <= '0;
      acc_first    <= '0;
      seen         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_cnt <= '0;
      first_diff   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr         <= a_in;
            b_sr         <= b_in;
            idx          <= '0;
            acc_cnt      <= '0;
            acc_first    <= '0;
            seen         <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_diff   <= '0;
            busy         <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          acc_cnt   <= nxt_cnt;
          acc_first <= nxt_first;
          seen      <= seen | diff;
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          if (last) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            equal        <= (nxt_cnt == '0);
            mismatch_cnt <= nxt_cnt;
            first_diff   <= nxt_first;
            state        <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_serial_cmp_ctrl.sv
// Directed self-checking bench for xnor_serial_cmp_ctrl (W=8).
// Expectations follow the XNOR_CMP_EARLY_EXIT_EN setting of the build.
module tb_xnor_serial_cmp_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic          equal;
  logic [CW-1:0] mismatch_cnt;
  logic [IW-1:0] first_diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xnor_serial_cmp_ctrl #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_cnt (mismatch_cnt),
    .first_diff   (first_diff)
  );

`ifdef XNOR_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a start at E0, then count edges until done; lat=-1 on timeout.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcyc);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = -1;
    bcyc  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) bcyc++;
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_res(input string nm, input int lat, input int elat,
                         input logic eq, input int cnt, input int fd);
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", nm, lat, elat);
    end
    checks++;
    if ({equal, 4'(mismatch_cnt), 3'(first_diff)} !==
        {eq, 4'(cnt), 3'(fd)}) begin
      errors++;
      $display("FAIL %s result got eq=%0b cnt=%0d fd=%0d exp eq=%0b cnt=%0d fd=%0d",
               nm, equal, mismatch_cnt, first_diff, eq, cnt, fd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      start = 1'($urandom);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, equal, mismatch_cnt, first_diff} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got b=%0b d=%0b e=%0b c=%0d f=%0d exp all 0",
               busy, done, equal, mismatch_cnt, first_diff);
    end
  endtask

  task automatic test_equal();
    int lat, bc;
    run_cmp(8'hA5, 8'hA5, lat, bc);
    chk_res("equal_a5", lat, 8, 1'b1, 0, 0);
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL busy_cycles got %0d exp 8", bc);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %0b exp 0", done);
    end
    a_in = 8'h00;
    repeat (3) step();
    checks++;
    if ({equal, mismatch_cnt} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL result_hold got eq=%0b cnt=%0d exp eq=1 cnt=0",
               equal, mismatch_cnt);
    end
  endtask

  task automatic test_mismatch();
    int lat, bc;
    run_cmp(8'hFF, 8'h00, lat, bc);
    chk_res("all_diff", lat, EE ? 1 : 8, 1'b0, EE ? 1 : 8, 0);
    repeat (2) step();
    run_cmp(8'h80, 8'h00, lat, bc);
    chk_res("msb_diff", lat, 8, 1'b0, 1, 7);
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    a_in  = 8'h80;
    b_in  = 8'h00;
    start = 1'b1;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 3) a_in = 8'hC0;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    chk_res("held_start_first", lat, 8, 1'b0, 1, 7);
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL held_done_width got %0b exp 0", done);
    end
    gap = -1;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (done) begin
        gap = k;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (gap < W + 1) begin
      errors++;
      $display("FAIL held_gap got %0d exp >= %0d", gap, W + 1);
    end
    chk_res("held_start_second", 7, 7, 1'b0, EE ? 1 : 2, 6);
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    a_in  = 8'h0F;
    b_in  = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, done, equal, mismatch_cnt, first_diff} !== '0) begin
      errors++;
      $display("FAIL mid_reset got b=%0b d=%0b e=%0b c=%0d f=%0d exp all 0",
               busy, done, equal, mismatch_cnt, first_diff);
    end
    run_cmp(8'h3C, 8'h3C, lat, bc);
    chk_res("after_reset", lat, 8, 1'b1, 0, 0);
    repeat (2) step();
  endtask

  task automatic test_early_exit();
    int lat, bc;
    run_cmp(8'h10, 8'h00, lat, bc);
    chk_res("bit4_diff", lat, EE ? 5 : 8, 1'b0, 1, 4);
    repeat (2) step();
    run_cmp(8'h01, 8'h03, lat, bc);
    chk_res("bit1_diff", lat, EE ? 2 : 8, 1'b0, 1, 1);
    repeat (2) step();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    test_reset();
    test_equal();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_early_exit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
